// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: PC request channel, ROM read port and instruction delivery channel.
// Signal suffixes are relative to instr_fetch; the slave modport is the fetch unit itself.
interface instr_fetch_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [15:0]       pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [DATA_W-1:0] instr_o;
  logic [15:0]       instr_pc_o;
  logic              instr_valid_o;
  logic              instr_ready_i;

  modport slave (
    input  pc_i, pc_valid_i, rom_data_i, instr_ready_i,
    output pc_ready_o, rom_en_o, rom_addr_o, instr_o, instr_pc_o, instr_valid_o
  );

  modport master (
    output pc_i, pc_valid_i, rom_data_i, instr_ready_i,
    input  pc_ready_o, rom_en_o, rom_addr_o, instr_o, instr_pc_o, instr_valid_o
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC request -> 1-cycle ROM read -> small response FIFO -> decode.
// Fetch-to-instr_valid_o latency 2 cycles; requests stall when buffered + in-flight fills the FIFO.
module instr_fetch #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          flush_i,
  instr_fetch_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [15:0]       inflight_pc_q, inflight_pc_d;
  logic [15:0]       pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [CW:0] occupancy;
  logic        accept;
  logic        push;
  logic        pop;

  // Credit counts the response already in flight, so a ROM reply always has a slot.
  assign occupancy       = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign bus.pc_ready_o  = !flush_i && (occupancy < (CW+1)'(DEPTH));
  assign accept          = bus.pc_valid_i && bus.pc_ready_o;

  assign bus.rom_en_o    = accept;
  assign bus.rom_addr_o  = bus.pc_i[ADDR_W-1:0];

  assign push            = inflight_q && !flush_i;
  assign bus.instr_valid_o = (count_q != '0);
  assign pop             = bus.instr_valid_o && bus.instr_ready_i && !flush_i;

  assign bus.instr_o     = data_mem_q[rd_ptr_q];
  assign bus.instr_pc_o  = pc_mem_q[rd_ptr_q];

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = accept;
    inflight_pc_d = accept ? bus.pc_i : inflight_pc_q;

    if (flush_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      data_mem_q[wr_ptr_q] <= bus.rom_data_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: accepted fetches queue an expected {pc, word},
// delivered instructions pop and compare. ROM model returns 16'hA000 + address.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  instr_fetch #(.ADDR_W(15), .DATA_W(16), .DEPTH(2)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .flush_i  (flush),
    .bus      (bus)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return 16'hA000 + {1'b0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en_o) bus.rom_data_i <= rom_word(bus.rom_addr_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step(output bit accepted, output bit emitted);
    exp_t e;
    #1;
    accepted = rst_n && bus.pc_valid_i && bus.pc_ready_o;
    emitted  = 1'b0;
    if (rst_n && flush) begin
      sb.delete();
    end else if (rst_n && bus.instr_valid_o && bus.instr_ready_i) begin
      emitted = 1'b1;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("instr", bus.instr_o, e.data);
        check("instr_pc", bus.instr_pc_o, e.pc);
      end
    end
    if (accepted) begin
      e.pc   = bus.pc_i;
      e.data = rom_word(bus.pc_i[14:0]);
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    bit a, em;
    bus.pc_valid_i    = 1'b0;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) step(a, em);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, em;
    int next_pc, n_acc, n_out, first_acc, first_vld;

    rst_n = 1'b0; flush = 1'b0;
    bus.pc_i = '0; bus.pc_valid_i = 1'b0; bus.instr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.instr_valid_o, 0);
    check("rst_instr", bus.instr_o, 0);
    check("rst_instr_pc", bus.instr_pc_o, 0);
    check("rst_rom_en", bus.rom_en_o, 0);
    check("rst_pc_ready", bus.pc_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream pc 0..3 with decode always ready
    next_pc = 0; n_out = 0; first_acc = -1; first_vld = -1;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 40 && n_out < 4; i++) begin
      bus.pc_valid_i = (next_pc < 4);
      bus.pc_i       = 16'(next_pc);
      step(a, em);
      if (a) begin
        if (first_acc < 0) first_acc = cyc - 1;
        next_pc++;
      end
      if (em) begin
        if (first_vld < 0) first_vld = cyc - 1;
        n_out++;
      end
    end
    check("stream_count", n_out, 4);
    check("first_latency", first_vld - first_acc, 2);

    // Decode stalled: only two fetches accepted, head held stable
    bus.instr_ready_i = 1'b0;
    next_pc = 16'h10; n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 16'(next_pc);
      step(a, em);
      if (a) begin n_acc++; next_pc++; end
      if (bus.instr_valid_o) check("hold_instr", bus.instr_o, 16'hA010);
    end
    check("stall_accepts", n_acc, 2);
    #1;
    check("stall_pc_ready", bus.pc_ready_o, 0);
    drain(10);
    #1;
    check("no_dup_valid", bus.instr_valid_o, 0);

    // Flush one cycle after requesting pc=5
    bus.instr_ready_i = 1'b1;
    bus.pc_valid_i = 1'b1; bus.pc_i = 16'h0005;
    step(a, em);
    check("pc5_accept", a, 1);
    flush = 1'b1; bus.pc_i = 16'h0020;
    #1;
    check("flush_pc_ready", bus.pc_ready_o, 0);
    check("flush_rom_en", bus.rom_en_o, 0);
    step(a, em);
    flush = 1'b0;
    #1;
    check("post_flush_valid", bus.instr_valid_o, 0);
    step(a, em);
    check("pc20_accept", a, 1);
    drain(6);

    // Fill FIFO to two entries, then flush while decode is ready
    bus.instr_ready_i = 1'b0;
    next_pc = 16'h30;
    for (int i = 0; i < 4; i++) begin
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 16'(next_pc);
      step(a, em);
      if (a) next_pc++;
    end
    bus.pc_valid_i = 1'b0;
    step(a, em);
    check("full_valid", bus.instr_valid_o, 1);
    check("full_pc_ready", bus.pc_ready_o, 0);
    flush = 1'b1; bus.instr_ready_i = 1'b1;
    step(a, em);
    flush = 1'b0;
    #1;
    check("flushed_valid", bus.instr_valid_o, 0);
    check("flushed_pc_ready", bus.pc_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step(a, em);
      check("flushed_quiet", bus.instr_valid_o, 0);
    end

    // Upper PC bit ignored for addressing, kept in instr_pc_o
    bus.pc_valid_i = 1'b1; bus.pc_i = 16'h8003;
    #1;
    check("rom_addr_trunc", bus.rom_addr_o, 15'h0003);
    check("rom_en_hi", bus.rom_en_o, 1);
    step(a, em);
    drain(6);

    // Asynchronous reset with one buffered, one in flight
    bus.instr_ready_i = 1'b0;
    bus.pc_valid_i = 1'b1; bus.pc_i = 16'h0040;
    step(a, em);
    bus.pc_i = 16'h0041;
    step(a, em);
    bus.pc_valid_i = 1'b0;
    #1;
    check("pre_rst_valid", bus.instr_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.instr_valid_o, 0);
    check("async_rst_instr", bus.instr_o, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(a, em);
      check("post_rst_quiet", bus.instr_valid_o, 0);
    end
    bus.pc_valid_i = 1'b1; bus.pc_i = 16'h0050;
    step(a, em);
    check("post_rst_accept", a, 1);
    drain(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
